// File: rtl/hazard_fwd_ctrl.sv
// hazard_fwd_ctrl: EX/MEM/WB destination shadow driving operand forwarding, load-use stall, bubble and flush.
// Defining HAZ_STALL_CNT_EN adds a saturating 16-bit stall_cnt output.
module hazard_fwd_ctrl #(
  parameter int REG_AW = 4,
  parameter bit R0_HARDWIRED = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_wr,
  input  logic              id_is_load,
  input  logic              flush_in,
  input  logic              mem_busy,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic              stall,
  output logic              bubble_ex,
  output logic              flush_id
`ifdef HAZ_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);
  typedef struct packed {
    logic              v;
    logic [REG_AW-1:0] rd;
    logic              wr;
    logic              ld;
  } ent_t;
  ent_t ex, mem, wb;
  logic a_ex, a_mem, a_wb, b_ex, b_mem, b_wb, lu;
  function automatic logic hit(ent_t e, logic [REG_AW-1:0] s, logic u);
    return u && e.v && e.wr && e.rd == s && !(R0_HARDWIRED && e.rd == '0);
  endfunction
  assign a_ex  = id_valid && hit(ex,  id_rs1, id_use_rs1);
  assign a_mem = id_valid && hit(mem, id_rs1, id_use_rs1);
  assign a_wb  = id_valid && hit(wb,  id_rs1, id_use_rs1);
  assign b_ex  = id_valid && hit(ex,  id_rs2, id_use_rs2);
  assign b_mem = id_valid && hit(mem, id_rs2, id_use_rs2);
  assign b_wb  = id_valid && hit(wb,  id_rs2, id_use_rs2);
  // A load still in EX has no result yet, so its consumer reads 00 and waits a cycle.
  assign lu = (a_ex || b_ex) && ex.ld;
  assign fwd_a_sel = a_ex ? (ex.ld ? 2'b00 : 2'b01) : a_mem ? 2'b10 : a_wb ? 2'b11 : 2'b00;
  assign fwd_b_sel = b_ex ? (ex.ld ? 2'b00 : 2'b01) : b_mem ? 2'b10 : b_wb ? 2'b11 : 2'b00;
  assign stall     = mem_busy || (!flush_in && lu);
  assign bubble_ex = !mem_busy && (flush_in || lu);
  assign flush_id  = !mem_busy && flush_in;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex  <= '0;
      mem <= '0;
      wb  <= '0;
    end else if (!mem_busy) begin
      ex  <= bubble_ex ? '0 : {id_valid, id_rd, id_reg_wr, id_is_load};
      mem <= ex;
      wb  <= mem;
    end
  end
`ifdef HAZ_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt <= '0;
    else if (stall && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// tb_hazard_fwd_ctrl: directed vector table, reset corner and random run against an in-flight instruction model.
module tb_hazard_fwd_ctrl;
  logic clk = 0, rst_n = 0;
  logic id_valid, id_use_rs1, id_use_rs2, id_reg_wr, id_is_load, flush_in, mem_busy;
  logic [3:0] id_rs1, id_rs2, id_rd;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic stall, bubble_ex, flush_id;
  int total = 0, passed = 0;
  logic [15:0] mcnt = 0;
`ifdef HAZ_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif
  hazard_fwd_ctrl #(.REG_AW(4), .R0_HARDWIRED(1)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_reg_wr(id_reg_wr),
    .id_is_load(id_is_load), .flush_in(flush_in), .mem_busy(mem_busy),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .stall(stall), .bubble_ex(bubble_ex),
    .flush_id(flush_id)
`ifdef HAZ_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic v; logic [3:0] rs1, rs2; logic u1, u2; logic [3:0] rd; logic wr, ld, fl, busy;
  } in_t;
  typedef struct {
    in_t i; logic [1:0] a, b; logic st, bu, fl;
  } vec_t;
  typedef struct packed { logic v; logic [3:0] rd; logic wr, ld; } ins_t;
  ins_t pipe[$];
  vec_t tbl[$];
  function automatic in_t mk(logic v, logic [3:0] rs1, rs2, logic u1, u2, logic [3:0] rd,
                             logic wr, ld, fl, busy);
    return '{v, rs1, rs2, u1, u2, rd, wr, ld, fl, busy};
  endfunction
  function automatic void add(in_t i, logic [1:0] a, b, logic st, bu, fl);
    vec_t t;
    t.i = i; t.a = a; t.b = b; t.st = st; t.bu = bu; t.fl = fl;
    tbl.push_back(t);
  endfunction
  task automatic chk(string n, logic [15:0] act, logic [15:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, want %0h (t=%0t)", n, act, exp, $time);
  endtask
  task automatic drive(in_t x);
    id_valid = x.v; id_rs1 = x.rs1; id_rs2 = x.rs2; id_use_rs1 = x.u1; id_use_rs2 = x.u2;
    id_rd = x.rd; id_reg_wr = x.wr; id_is_load = x.ld; flush_in = x.fl; mem_busy = x.busy;
  endtask
  // Age 0 is the youngest in-flight instruction; the youngest writer of a source supplies it.
  function automatic logic writes(ins_t e, logic [3:0] s);
    return e.v && e.wr && e.rd == s && e.rd != 0;
  endfunction
  function automatic vec_t model(in_t x);
    vec_t m;
    logic lu;
    m.i = x; m.a = 0; m.b = 0;
    if (x.v) begin
      for (int k = 2; k >= 0; k--) begin
        if (x.u1 && writes(pipe[k], x.rs1)) m.a = (k == 0 && pipe[0].ld) ? 2'd0 : 2'(k + 1);
        if (x.u2 && writes(pipe[k], x.rs2)) m.b = (k == 0 && pipe[0].ld) ? 2'd0 : 2'(k + 1);
      end
    end
    lu = x.v && pipe[0].ld && ((x.u1 && writes(pipe[0], x.rs1)) || (x.u2 && writes(pipe[0], x.rs2)));
    m.st = x.busy || (lu && !x.fl);
    m.bu = !x.busy && (x.fl || lu);
    m.fl = !x.busy && x.fl;
    return m;
  endfunction
  task automatic model_reset();
    pipe = '{3{ins_t'(0)}};
    mcnt = 0;
  endtask
  task automatic cyc(vec_t t, bit use_tbl);
    vec_t m;
    drive(t.i);
    #2;
    m = model(t.i);
    if (use_tbl) m = t;
    chk("fwd_a_sel", 16'(fwd_a_sel), 16'(m.a));
    chk("fwd_b_sel", 16'(fwd_b_sel), 16'(m.b));
    chk("stall", 16'(stall), 16'(m.st));
    chk("bubble_ex", 16'(bubble_ex), 16'(m.bu));
    chk("flush_id", 16'(flush_id), 16'(m.fl));
`ifdef HAZ_STALL_CNT_EN
    chk("stall_cnt", stall_cnt, mcnt);
`endif
    m = model(t.i);
    @(posedge clk);
    if (m.st && mcnt != 16'hFFFF) mcnt++;
    if (!t.i.busy) begin
      pipe.push_front(m.bu ? ins_t'(0) : ins_t'({t.i.v, t.i.rd, t.i.wr, t.i.ld}));
      void'(pipe.pop_back());
    end
    #1;
  endtask
  initial begin
    vec_t r;
    drive(in_t'(0));
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    add(mk(0,0,0,0,0,0,0,0,0,0), 0, 0, 0, 0, 0);
    add(mk(1,0,0,0,0,3,1,0,0,0), 0, 0, 0, 0, 0);
    add(mk(1,3,0,1,0,0,0,0,0,0), 1, 0, 0, 0, 0);
    add(mk(1,3,0,1,0,0,0,0,0,0), 2, 0, 0, 0, 0);
    add(mk(1,3,0,1,0,0,0,0,0,0), 3, 0, 0, 0, 0);
    add(mk(1,3,0,1,0,0,0,0,0,0), 0, 0, 0, 0, 0);
    add(mk(1,0,0,0,0,5,1,1,0,0), 0, 0, 0, 0, 0);
    add(mk(1,0,5,0,1,0,0,0,0,0), 0, 0, 1, 1, 0);
    add(mk(1,0,5,0,1,0,0,0,0,0), 0, 2, 0, 0, 0);
    add(mk(1,0,0,0,0,0,1,0,0,0), 0, 0, 0, 0, 0);
    add(mk(1,0,0,0,0,2,1,0,0,0), 0, 0, 0, 0, 0);
    add(mk(1,0,2,1,1,0,0,0,0,0), 0, 1, 0, 0, 0);
    add(mk(1,0,0,0,0,4,1,1,0,0), 0, 0, 0, 0, 0);
    add(mk(1,4,0,1,0,0,0,0,1,0), 0, 0, 0, 1, 1);
    add(mk(1,4,0,1,0,0,0,0,0,0), 2, 0, 0, 0, 0);
    add(mk(1,0,0,0,0,7,1,0,0,0), 0, 0, 0, 0, 0);
    add(mk(0,0,0,0,0,0,0,0,0,0), 0, 0, 0, 0, 0);
    repeat (3) add(mk(1,7,0,1,0,0,0,0,0,1), 2, 0, 1, 0, 0);
    add(mk(1,7,0,1,0,0,0,0,0,0), 2, 0, 0, 0, 0);
    add(mk(1,7,7,1,1,0,0,0,0,0), 3, 3, 0, 0, 0);
    add(mk(0,7,0,1,0,0,0,0,0,0), 0, 0, 0, 0, 0);
    add(mk(0,0,0,0,0,0,0,0,1,1), 0, 0, 1, 0, 0);
    foreach (tbl[k]) cyc(tbl[k], 1);
    // Reset arriving mid-cycle while a load-use stall is pending must clear it at once.
    r.i = mk(1,0,0,0,0,6,1,1,0,0);
    cyc(r, 0);
    drive(mk(1,6,0,1,0,0,0,0,0,0));
    #2 chk("lu_before_rst", 16'(stall), 16'd1);
    rst_n = 0;
    #1;
    chk("rst_stall", 16'(stall), 16'd0);
    chk("rst_bubble", 16'(bubble_ex), 16'd0);
    chk("rst_a_sel", 16'(fwd_a_sel), 16'd0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1;
    r.i = mk(0,0,0,0,0,0,0,0,0,0);
    cyc(r, 0);
    for (int n = 0; n < 3000; n++) begin
      r.i = mk($urandom_range(0, 3) != 0, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
               1'($urandom), 1'($urandom), 4'($urandom_range(0, 3)), 1'($urandom),
               $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0);
      cyc(r, 0);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
